// File: rtl/fixed_divmod.sv
// Purpose: sequential signed divider returning floored quotient/remainder (q = floor(a/b), r = a - b*q).
// Latency: W+2 edges from accept to out_valid (1 edge for divide-by-zero / overflow); one op in flight.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so new operands stall meanwhile.
module fixed_divmod #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    localparam int CW = $clog2(W);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    state_t        state_q, state_d;
    logic [W-1:0]  dvd_q, dvd_d;       // |a|, shifted out MSB first
    logic [W-1:0]  bmag_q, bmag_d;     // |b|
    logic [W-1:0]  bsgn_q, bsgn_d;     // b as given, for the floor correction
    logic [W:0]    rem_q, rem_d;       // partial remainder
    logic [W-1:0]  quo_q, quo_d;       // quotient magnitude
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sa_q, sa_d, sb_q, sb_d;
    logic [W-1:0]  quot_q, quot_d, remo_q, remo_d;
    logic          dbz_q, dbz_d, ovf_q, ovf_d;

    // Next-state and datapath: accept, restoring iterations, sign/floor fix-up, hold result.
    always_comb begin
        logic [W-1:0] a_abs, b_abs, q_t, r_t;
        logic [W+1:0] rem_sh, diff;
        state_d = state_q;
        dvd_d   = dvd_q;
        bmag_d  = bmag_q;
        bsgn_d  = bsgn_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        a_abs   = dividend[W-1] ? -dividend : dividend;
        b_abs   = divisor[W-1] ? -divisor : divisor;
        rem_sh  = {rem_q, dvd_q[W-1]};
        diff    = rem_sh - {2'b00, bmag_q};
        q_t     = (sa_q ^ sb_q) ? -quo_q : quo_q;
        r_t     = sa_q ? -rem_q[W-1:0] : rem_q[W-1:0];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // -2^(W-1) negates to itself, which reads as unsigned 2^(W-1).
                    dvd_d  = a_abs;
                    bmag_d = b_abs;
                    bsgn_d = divisor;
                    sa_d   = dividend[W-1];
                    sb_d   = divisor[W-1];
                    rem_d  = '0;
                    quo_d  = '0;
                    quot_d = '0;
                    remo_d = '0;
                    dbz_d  = 1'b0;
                    ovf_d  = 1'b0;
                    if (divisor == '0) begin
                        remo_d  = dividend;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else if (dividend == MIN_VAL && divisor == '1) begin
                        quot_d  = MIN_VAL;
                        ovf_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_d   = CW'(W - 1);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dvd_d = dvd_q << 1;
                if (!diff[W+1]) begin
                    rem_d = diff[W:0];
                    quo_d = {quo_q[W-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[W:0];
                    quo_d = {quo_q[W-2:0], 1'b0};
                end
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - CW'(1);
            end
            FIX: begin
                // Truncated result becomes floored when the remainder's sign disagrees with b.
                if (r_t != '0 && r_t[W-1] != sb_q) begin
                    quot_d = q_t - W'(1);
                    remo_d = r_t + bsgn_q;
                end else begin
                    quot_d = q_t;
                    remo_d = r_t;
                end
                state_d = DONE;
            end
            default: begin
                if (out_ready) state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any division in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            bmag_q  <= '0;
            bsgn_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            bmag_q  <= bmag_d;
            bsgn_q  <= bsgn_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = remo_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_fixed_divmod.sv
// Purpose: self-checking bench for fixed_divmod at W=8 and W=16 (directed table plus random vs floor model).
// Latency: checks exact accept-to-out_valid edge counts.
// Backpressure: holds out_ready low with operands offered to confirm hold and ignore behaviour.
module tb_fixed_divmod;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, in_valid, out_ready, sel;
    int   a_drv, b_drv;

    logic       rdy8, ov8, dz8, of8;
    logic       rdy16, ov16, dz16, of16;
    logic [7:0] q8, r8;
    logic [15:0] q16, r16;

    fixed_divmod #(.W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & ~sel), .in_ready(rdy8),
        .dividend(a_drv[7:0]), .divisor(b_drv[7:0]), .out_valid(ov8),
        .out_ready(out_ready & ~sel), .quotient(q8), .remainder(r8),
        .div_by_zero(dz8), .overflow(of8)
    );

    fixed_divmod #(.W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid & sel), .in_ready(rdy16),
        .dividend(a_drv[15:0]), .divisor(b_drv[15:0]), .out_valid(ov16),
        .out_ready(out_ready & sel), .quotient(q16), .remainder(r16),
        .div_by_zero(dz16), .overflow(of16)
    );

    logic in_ready_m, out_valid_m, dbz_m, ovf_m;
    int   q_m, r_m;
    assign in_ready_m  = sel ? rdy16 : rdy8;
    assign out_valid_m = sel ? ov16 : ov8;
    assign dbz_m       = sel ? dz16 : dz8;
    assign ovf_m       = sel ? of16 : of8;
    assign q_m         = sel ? int'($signed(q16)) : int'($signed(q8));
    assign r_m         = sel ? int'($signed(r16)) : int'($signed(r8));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: floored division straight from the definition, using real arithmetic.
    task automatic model(input int w, input int a, input int b,
                         output int q, output int r, output int dz, output int of, output int lat);
        int mn;
        mn = -(1 << (w - 1));
        dz = 0; of = 0;
        if (b == 0) begin
            q = 0; r = a; dz = 1; lat = 1;
        end else if (a == mn && b == -1) begin
            q = mn; r = 0; of = 1; lat = 1;
        end else begin
            q = int'($floor(real'(a) / real'(b)));
            r = a - b * q;
            lat = w + 2;
        end
    endtask

    // Offer one operation, measure latency, check result, optionally stall out_ready, then release.
    task automatic do_div(input int w, input int a, input int b, input int eq, input int er,
                          input int edz, input int eof, input int elat, input int hold);
        bit acc;
        int lat;
        sel = (w == 16);
        a_drv = a;
        b_drv = b;
        in_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = in_ready_m;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        a_drv = $urandom;
        b_drv = $urandom;
        if (!acc) begin
            chk("accept_timeout", 0, 1);
            return;
        end
        lat = 1;
        while (!out_valid_m && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, elat);
        chk("out_valid", int'(out_valid_m), 1);
        chk("quotient", q_m, eq);
        chk("remainder", r_m, er);
        chk("div_by_zero", int'(dbz_m), edz);
        chk("overflow", int'(ovf_m), eof);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a_drv = $urandom;
            b_drv = $urandom;
            @(posedge clk); #1;
            chk("hold_out_valid", int'(out_valid_m), 1);
            chk("hold_in_ready", int'(in_ready_m), 0);
            chk("hold_quotient", q_m, eq);
            chk("hold_remainder", r_m, er);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_out_valid", int'(out_valid_m), 0);
        chk("release_in_ready", int'(in_ready_m), 1);
    endtask

    function automatic int pick(input int w);
        int v;
        case ($urandom_range(0, 7))
            0: v = 0;
            1: v = -(1 << (w - 1));
            2: v = (1 << (w - 1)) - 1;
            3: v = -1;
            default: begin
                v = $urandom;
                v = (v << (32 - w)) >>> (32 - w);
            end
        endcase
        return v;
    endfunction

    typedef struct {
        int w, a, b, q, r, dz, of, lat;
    } vec_t;

    vec_t vt[12];

    initial begin
        int q, r, dz, of, lat, a, b;

        vt[0]  = '{8,     7,    2,      3,   1, 0, 0, 10};
        vt[1]  = '{8,    -7,    2,     -4,   1, 0, 0, 10};
        vt[2]  = '{8,     7,   -2,     -4,  -1, 0, 0, 10};
        vt[3]  = '{8,    -7,   -2,      3,  -1, 0, 0, 10};
        vt[4]  = '{8,  -128,    2,    -64,   0, 0, 0, 10};
        vt[5]  = '{8,   127, -128,     -1,  -1, 0, 0, 10};
        vt[6]  = '{8,  -128,  127,     -2, 126, 0, 0, 10};
        vt[7]  = '{8,  -128,   -1,   -128,   0, 0, 1, 1};
        vt[8]  = '{8,     5,    0,      0,   5, 1, 0, 1};
        vt[9]  = '{16, -32768, -1, -32768,   0, 0, 1, 1};
        vt[10] = '{16,  1000,  -7,   -143,  -1, 0, 0, 18};
        vt[11] = '{16,     0,   5,      0,   0, 0, 0, 18};

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        sel = 1'b0;
        a_drv = 0;
        b_drv = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int s = 0; s < 2; s++) begin
            sel = (s == 1);
            #1;
            chk("reset_in_ready", int'(in_ready_m), 1);
            chk("reset_out_valid", int'(out_valid_m), 0);
            chk("reset_quotient", q_m, 0);
            chk("reset_remainder", r_m, 0);
            chk("reset_flags", int'(dbz_m) + int'(ovf_m), 0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++)
            do_div(vt[i].w, vt[i].a, vt[i].b, vt[i].q, vt[i].r, vt[i].dz, vt[i].of, vt[i].lat, 0);

        // Backpressure: result held for 20 cycles while new operands are offered and ignored.
        do_div(8, 9, 4, 2, 1, 0, 0, 10, 20);

        // Reset in the middle of CALC aborts immediately.
        sel = 1'b0;
        a_drv = 100;
        b_drv = 7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", int'(out_valid_m), 0);
        chk("midreset_in_ready", int'(in_ready_m), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("postreset_out_valid", int'(out_valid_m), 0);
        do_div(8, 100, 7, 14, 2, 0, 0, 10, 0);

        // Random operands with gaps on both handshakes.
        for (int wsel = 0; wsel < 2; wsel++) begin
            int w;
            w = (wsel == 0) ? 8 : 16;
            for (int n = 0; n < 1500; n++) begin
                a = pick(w);
                b = pick(w);
                model(w, a, b, q, r, dz, of, lat);
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                do_div(w, a, b, q, r, dz, of, lat, $urandom_range(0, 2));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
